// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and iteration count for the 16/8 divider.
// DIV_APPROX_EN selects the shortened 6-iteration approximate mode.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned CNT_W      = 3;

`ifdef DIV_APPROX_EN
    localparam int unsigned ITER = 6;
`else
    localparam int unsigned ITER = 8;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_16x8_seq_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface div_16x8_seq_if
    import div_pkg::*;
    ;

    logic                  start;
    logic [DIVIDEND_W-1:0] A;
    logic [DIVISOR_W-1:0]  B;
    logic                  busy;
    logic                  done;
    logic [DIVISOR_W-1:0]  Q;
    logic [DIVISOR_W-1:0]  R;
    logic                  ovf;
    logic                  dz;

    modport master (output start, A, B, input busy, done, Q, R, ovf, dz);
    modport slave  (input start, A, B, output busy, done, Q, R, ovf, dz);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: trial-subtract and shift a quotient bit in.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic [DIVISOR_W-1:0] sh,
    input  logic [DIVISOR_W-1:0] b,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic [DIVISOR_W-1:0] sh_next
);

    logic [DIVISOR_W:0] trial;
    logic               fits;

    // A set rem MSB puts the shifted partial at >= 256, so the subtract always fits.
    always_comb begin
        trial = {rem, sh[DIVISOR_W-1]} - {1'b0, b};
        fits  = rem[DIVISOR_W-1] | ~trial[DIVISOR_W];
        if (fits) begin
            rem_next = trial[DIVISOR_W-1:0];
            sh_next  = {sh[DIVISOR_W-2:0], 1'b1};
        end else begin
            rem_next = {rem[DIVISOR_W-2:0], sh[DIVISOR_W-1]};
            sh_next  = {sh[DIVISOR_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential radix-2 restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per cycle.
// Define DIV_APPROX_EN for the 6-iteration approximate mode (Q[1:0]=0, R=0).
module div_16x8_seq
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_16x8_seq_if.slave  bus
);

    state_t               state, state_n;
    logic [DIVISOR_W-1:0] b_r, b_n;
    logic [DIVISOR_W-1:0] rem, rem_n;
    logic [DIVISOR_W-1:0] sh, sh_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [DIVISOR_W-1:0] q_r, q_n;
    logic [DIVISOR_W-1:0] r_r, r_n;
    logic                 ovf_r, ovf_n;
    logic                 dz_r, dz_n;
    logic                 busy_r, busy_n;
    logic                 done_r, done_n;
    logic [DIVISOR_W-1:0] step_rem;
    logic [DIVISOR_W-1:0] step_sh;

    div_step u_step (
        .rem      (rem),
        .sh       (sh),
        .b        (b_r),
        .rem_next (step_rem),
        .sh_next  (step_sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            b_r    <= '0;
            rem    <= '0;
            sh     <= '0;
            cnt    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            b_r    <= b_n;
            rem    <= rem_n;
            sh     <= sh_n;
            cnt    <= cnt_n;
            q_r    <= q_n;
            r_r    <= r_n;
            ovf_r  <= ovf_n;
            dz_r   <= dz_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    // The dividend is loaded straight into rem/sh on accept; CHECK reads it from there.
    always_comb begin
        state_n = state;
        b_n     = b_r;
        rem_n   = rem;
        sh_n    = sh;
        cnt_n   = cnt;
        q_n     = q_r;
        r_n     = r_r;
        ovf_n   = ovf_r;
        dz_n    = dz_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = CHECK;
                    b_n     = bus.B;
                    rem_n   = bus.A[DIVIDEND_W-1:DIVISOR_W];
                    sh_n    = bus.A[DIVISOR_W-1:0];
                    ovf_n   = 1'b0;
                    dz_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            CHECK: begin
                if (b_r == '0) begin
                    dz_n    = 1'b1;
                    q_n     = '1;
                    r_n     = sh;
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (rem >= b_r) begin
                    ovf_n   = 1'b1;
                    q_n     = '1;
                    r_n     = '1;
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n   = CNT_W'(ITER - 1);
                    state_n = CALC;
                end
            end
            CALC: begin
                rem_n = step_rem;
                sh_n  = step_sh;
                if (cnt == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    q_n     = step_sh << (DIVISOR_W - ITER);
`ifdef DIV_APPROX_EN
                    r_n     = '0;
`else
                    r_n     = step_rem;
`endif
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Q    = q_r;
    assign bus.R    = r_r;
    assign bus.ovf  = ovf_r;
    assign bus.dz   = dz_r;

endmodule
